// File: rtl/param_div_unit.sv
// param_div_unit: queued iterative integer divider for DIV/DIVU/REM/REMU with in-order writeback.
// Optional macro DIV_RESULT_REUSE_EN lets a repeat op on the same operands reuse the previous result.
module param_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int ID_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [2:0]            issue_fn3,
    input  logic [DATA_WIDTH-1:0] issue_rs1,
    input  logic [DATA_WIDTH-1:0] issue_rs2,
    input  logic [4:0]            issue_rs1_addr,
    input  logic [4:0]            issue_rs2_addr,
    input  logic [4:0]            issue_rd_addr,
    input  logic [ID_WIDTH-1:0]   issue_id,
    input  logic                  rf_write_valid,
    input  logic [4:0]            rf_write_addr,
    input  logic                  flush,
    output logic                  wb_done,
    input  logic                  wb_ack,
    output logic [DATA_WIDTH-1:0] wb_rd,
    output logic [ID_WIDTH-1:0]   wb_id
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [W-1:0]        mag_a;
        logic [W-1:0]        mag_b;
        logic [CW-1:0]       clz_a;
        logic [CW-1:0]       clz_b;
        logic                div_zero;
        logic                rem_op;
        logic                neg_res;
        logic                reuse;
        logic [ID_WIDTH-1:0] id;
    } entry_t;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    function automatic logic [CW-1:0] clz(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = CW'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) n = CW'(W - 1 - i);
        return n;
    endfunction

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic en);
        return en ? (~v + W'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // control state
    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                wb_done_q, wb_done_d;
    logic [W-1:0]        wb_rd_q, wb_rd_d;
    logic [ID_WIDTH-1:0] wb_id_q, wb_id_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]       fill_q, fill_d;

    // datapath state
    entry_t              fifo_q [FIFO_DEPTH];
    logic [W-1:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]       itr_q, itr_d;
    logic                cur_rem_q, cur_rem_d, cur_neg_q, cur_neg_d;
    logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;

    logic                push, pop, sgn_in, reuse_hit;
    logic                start_run, done_now, core_step, core_last, ge;
    entry_t              in_e, head;
    logic [CW-1:0]       head_n;
    logic [W-1:0]        res;
    logic                unused_fn3_bit;

    assign unused_fn3_bit = issue_fn3[2];
    assign issue_ready    = (fill_q != NW'(FIFO_DEPTH));
    assign push           = issue_valid & issue_ready & ~flush;
    assign sgn_in         = ~issue_fn3[0];
    assign head           = fifo_q[rd_ptr_q];
    assign pop            = (fill_q != '0) & (~busy_q | (wb_ack & wb_done_q)) & ~flush;

`ifdef DIV_RESULT_REUSE_EN
    logic [4:0] last_rs1_q, last_rs1_d, last_rs2_q, last_rs2_d;
    logic       last_sgn_q, last_sgn_d, reuse_vld_q, reuse_vld_d;

    assign reuse_hit = reuse_vld_q && (issue_rs1_addr == last_rs1_q) &&
                       (issue_rs2_addr == last_rs2_q) && (sgn_in == last_sgn_q);

    always_comb begin
        last_rs1_d  = last_rs1_q;
        last_rs2_d  = last_rs2_q;
        last_sgn_d  = last_sgn_q;
        reuse_vld_d = reuse_vld_q;
        if (push) begin
            last_rs1_d  = issue_rs1_addr;
            last_rs2_d  = issue_rs2_addr;
            last_sgn_d  = sgn_in;
            reuse_vld_d = (issue_rd_addr != issue_rs1_addr) && (issue_rd_addr != issue_rs2_addr);
        end
        // any overwrite of a recorded source invalidates the retained result
        if (rf_write_valid && (rf_write_addr != 5'd0) &&
            ((rf_write_addr == last_rs1_d) || (rf_write_addr == last_rs2_d)))
            reuse_vld_d = 1'b0;
        if (flush)
            reuse_vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_rs1_q  <= '0;
            last_rs2_q  <= '0;
            last_sgn_q  <= 1'b0;
            reuse_vld_q <= 1'b0;
        end else begin
            last_rs1_q  <= last_rs1_d;
            last_rs2_q  <= last_rs2_d;
            last_sgn_q  <= last_sgn_d;
            reuse_vld_q <= reuse_vld_d;
        end
    end
`else
    logic unused_reuse_inputs;
    assign unused_reuse_inputs = ^{rf_write_valid, rf_write_addr, issue_rs1_addr,
                                   issue_rs2_addr, issue_rd_addr};
    assign reuse_hit = 1'b0;
`endif

    // issue decode: magnitudes, leading zeros and result sign
    always_comb begin
        logic a_neg, b_neg, b_zero;
        a_neg         = sgn_in & issue_rs1[W-1];
        b_neg         = sgn_in & issue_rs2[W-1];
        b_zero        = (issue_rs2 == '0);
        in_e          = '0;
        in_e.mag_a    = neg_if(issue_rs1, a_neg);
        in_e.mag_b    = neg_if(issue_rs2, b_neg);
        in_e.clz_a    = clz(in_e.mag_a);
        in_e.clz_b    = clz(in_e.mag_b);
        in_e.div_zero = b_zero;
        in_e.rem_op   = issue_fn3[1];
        in_e.neg_res  = issue_fn3[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
        in_e.reuse    = reuse_hit;
        in_e.id       = issue_id;
    end

    always_comb begin
        head_n = '0;
        if (!head.div_zero && (head.clz_b >= head.clz_a))
            head_n = head.clz_b - head.clz_a + CW'(1);
    end

    assign start_run = pop & ~head.reuse & (head_n != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_run) state_d = S_RUN;
            S_RUN:   if (itr_q == CW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush)
            state_d = S_IDLE;
    end

    always_comb begin
        core_step = (state_q == S_RUN);
        core_last = core_step && (itr_q == CW'(1));
    end

    // core datapath: load on pop, one restoring step per RUN cycle
    always_comb begin
        ge        = (rem_q >= dvs_q);
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        itr_d     = itr_q;
        cur_rem_d = cur_rem_q;
        cur_neg_d = cur_neg_q;
        cur_id_d  = cur_id_q;
        if (pop) begin
            cur_rem_d = head.rem_op;
            cur_neg_d = head.neg_res;
            cur_id_d  = head.id;
            if (!head.reuse) begin
                rem_d = head.mag_a;
                quo_d = head.div_zero ? '1 : '0;
                dvs_d = head.mag_b << (head.clz_b - head.clz_a);
                itr_d = head_n;
            end
        end else if (core_step) begin
            rem_d = ge ? (rem_q - dvs_q) : rem_q;
            quo_d = {quo_q[W-2:0], ge};
            dvs_d = dvs_q >> 1;
            itr_d = itr_q - CW'(1);
        end
    end

    assign done_now = ~flush & ((pop & (head.reuse | (head_n == '0))) | core_last);
    assign res      = neg_if(cur_rem_d ? rem_d : quo_d, cur_neg_d);

    always_comb begin
        wb_done_d = wb_done_q;
        busy_d    = busy_q;
        wb_rd_d   = wb_rd_q;
        wb_id_d   = wb_id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        if (wb_ack && wb_done_q) begin
            wb_done_d = 1'b0;
            busy_d    = 1'b0;
        end
        if (pop)
            busy_d = 1'b1;
        if (done_now) begin
            wb_done_d = 1'b1;
            wb_rd_d   = res;
            wb_id_d   = cur_id_d;
        end
        if (push)
            wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)
            fill_d = fill_q + NW'(1);
        else if (pop && !push)
            fill_d = fill_q - NW'(1);
        if (flush) begin
            wb_done_d = 1'b0;
            busy_d    = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            fill_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            wb_done_q <= 1'b0;
            wb_rd_q   <= '0;
            wb_id_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            wb_done_q <= wb_done_d;
            wb_rd_q   <= wb_rd_d;
            wb_id_q   <= wb_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= in_e;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvs_q     <= dvs_d;
        itr_q     <= itr_d;
        cur_rem_q <= cur_rem_d;
        cur_neg_q <= cur_neg_d;
        cur_id_q  <= cur_id_d;
    end

    assign wb_done = wb_done_q;
    assign wb_rd   = wb_rd_q;
    assign wb_id   = wb_id_q;

endmodule

// File: tb/tb_param_div_unit.sv
// Directed self-checking bench for param_div_unit (DATA_WIDTH=32, FIFO_DEPTH=2).
// Latency expectations follow DIV_RESULT_REUSE_EN when the bench is built with it.
module tb_param_div_unit;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
`ifdef DIV_RESULT_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [2:0]  issue_fn3 = '0;
    logic [31:0] issue_rs1 = '0, issue_rs2 = '0;
    logic [4:0]  issue_rs1_addr = '0, issue_rs2_addr = '0, issue_rd_addr = '0;
    logic [2:0]  issue_id = '0;
    logic        rf_write_valid = 1'b0;
    logic [4:0]  rf_write_addr = '0;
    logic        flush = 1'b0;
    logic        wb_done;
    logic        wb_ack = 1'b0;
    logic [31:0] wb_rd;
    logic [2:0]  wb_id;

    int n_tests = 0;
    int n_fail  = 0;

    param_div_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(2), .ID_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fn3(issue_fn3),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
        .issue_rd_addr(issue_rd_addr), .issue_id(issue_id),
        .rf_write_valid(rf_write_valid), .rf_write_addr(rf_write_addr),
        .flush(flush),
        .wb_done(wb_done), .wb_ack(wb_ack), .wb_rd(wb_rd), .wb_id(wb_id)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [2:0] id);
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_fn3      = fn3;
        issue_rs1      = a;
        issue_rs2      = b;
        issue_rs1_addr = r1;
        issue_rs2_addr = r2;
        issue_rd_addr  = rd;
        issue_id       = id;
        @(posedge clk);
        #1 issue_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (wb_done) break;
        end
        check_eq({tag, "_done"}, 64'(wb_done), 64'd1);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        wb_ack = 1'b1;
        @(posedge clk);
        #1 wb_ack = 1'b0;
        check_eq({tag, "_ackclr"}, 64'(wb_done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] fn3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [2:0] id,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        push(fn3, a, b, r1, r2, rd, id);
        wait_done(tag, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_rd"}, 64'(wb_rd), 64'(exp));
        check_eq({tag, "_id"}, 64'(wb_id), 64'(id));
        repeat (2) @(posedge clk);
        #1 check_eq({tag, "_hold"}, 64'({wb_done, wb_id, wb_rd}), 64'({1'b1, id, exp}));
        ack(tag);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 64'(issue_ready), 64'd1);
        check_eq({tag, "_done"}, 64'(wb_done), 64'd0);
        check_eq({tag, "_rd"}, 64'(wb_rd), 64'd0);
        check_eq({tag, "_id"}, 64'(wb_id), 64'd0);
    endtask

    // long op plus one queued op, then abort with flush or reset during RUN
    task automatic abort_case(input string tag, input bit use_reset);
        int seen;
        push(F_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd24, 5'd25, 5'd26, 3'd6);
        push(F_DIVU, 32'd8, 32'd2, 5'd27, 5'd28, 5'd29, 3'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (use_reset) rst_n = 1'b0;
        else flush = 1'b1;
        @(posedge clk);
        #1 begin
            rst_n = 1'b1;
            flush = 1'b0;
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (wb_done) seen++;
        end
        check_eq({tag, "_nodone"}, 64'(seen), 64'd0);
        check_eq({tag, "_ready"}, 64'(issue_ready), 64'd1);
        run_op({tag, "_next"}, F_DIVU, 32'd100, 32'd7, 5'd21, 5'd22, 5'd23, 3'd2, 32'd14, 6);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("reset");

        // 100/7: N = clz(7) - clz(100) + 1 = 29 - 25 + 1 = 5
        run_op("div100_7", F_DIV, 32'd100, 32'd7, 5'd5, 5'd6, 5'd7, 3'd1, 32'd14, 6);
        run_op("rem100_7", F_REM, 32'd100, 32'd7, 5'd5, 5'd6, 5'd7, 3'd2, 32'd2, REUSE ? 1 : 6);

        run_op("divu_by0", F_DIVU, 32'h1234, 32'd0, 5'd8, 5'd9, 5'd10, 3'd3, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", F_REMU, 32'h1234, 32'd0, 5'd8, 5'd9, 5'd10, 3'd4, 32'h1234, 1);

        // signed overflow: |a| = 2^31, |b| = 1, N = 32
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 5'd12, 5'd13, 3'd5,
               32'h8000_0000, 33);
        run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 5'd12, 5'd13, 3'd6,
               32'd0, REUSE ? 1 : 33);

        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14, 5'd15, 5'd16, 3'd7,
               32'hFFFF_FFFD, 3);
        run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd14, 5'd15, 5'd16, 3'd0,
               32'hFFFF_FFFF, REUSE ? 1 : 3);

        // rd equals rs1: no reuse possible, both run the core (N = 29 - 26 + 1 = 4)
        run_op("divu_50_5", F_DIVU, 32'd50, 32'd5, 5'd1, 5'd2, 5'd1, 3'd1, 32'd10, 5);
        run_op("remu_50_5", F_REMU, 32'd50, 32'd5, 5'd1, 5'd2, 5'd1, 3'd2, 32'd0, 5);

        // source overwrite between the pair kills reuse (N = 30 - 28 + 1 = 3)
        run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 5'd3, 5'd4, 5'd20, 3'd3, 32'd3, 4);
        @(negedge clk);
        rf_write_valid = 1'b1;
        rf_write_addr  = 5'd4;
        @(posedge clk);
        #1 rf_write_valid = 1'b0;
        run_op("remu_9_3", F_REMU, 32'd9, 32'd3, 5'd3, 5'd4, 5'd20, 3'd4, 32'd0, 4);

        // back-to-back issue with no ack: one op in the core plus FIFO_DEPTH queued
        push(F_DIVU, 32'd1000, 32'd10, 5'd17, 5'd18, 5'd19, 3'd3);
        push(F_DIVU, 32'd77, 32'd7, 5'd20, 5'd21, 5'd22, 3'd4);
        push(F_REMU, 32'd77, 32'd5, 5'd23, 5'd24, 5'd25, 3'd5);
        check_eq("full_ready", 64'(issue_ready), 64'd0);
        wait_done("q0", lat);
        check_eq("q0_rd", 64'(wb_rd), 64'd100);
        check_eq("q0_id", 64'(wb_id), 64'd3);
        check_eq("q0_ready", 64'(issue_ready), 64'd0);
        ack("q0");
        wait_done("q1", lat);
        check_eq("q1_rd", 64'(wb_rd), 64'd11);
        check_eq("q1_id", 64'(wb_id), 64'd4);
        ack("q1");
        wait_done("q2", lat);
        check_eq("q2_rd", 64'(wb_rd), 64'd2);
        check_eq("q2_id", 64'(wb_id), 64'd5);
        ack("q2");
        check_eq("q_empty_ready", 64'(issue_ready), 64'd1);

        abort_case("flush", 1'b0);
        abort_case("rst", 1'b1);

        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("reset2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
